bram_count_accumulator: RTL
===========================

BRAM_COUNT_ACCUMULATOR -- requirements
Module: bram_count_accumulator

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the BRAM address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the BRAM word and counter width.
REQ-003 Parameter DEPTH, default 128, SHALL set the number of counters swept by clear and dump (DEPTH <= 2^ADDR_W).
REQ-004 clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 evt_valid  in  1  SHALL mark a measurement-outcome event.
REQ-007 evt_addr  in  ADDR_W  SHALL be the outcome counter index.
REQ-008 evt_ready  out  1  SHALL indicate that an event is accepted this cycle.
REQ-009 clr_start  in  1  SHALL be a single-cycle pulse that zeroes all counters.
REQ-010 dump_start  in  1  SHALL be a single-cycle pulse that streams out and clears all counters.
REQ-011 out_valid / out_ready / out_data[DATA_W] / out_addr[ADDR_W] / out_last  SHALL form the dump stream (out_ready is an input; the rest are outputs).
REQ-012 bram_en, bram_we, bram_addr[ADDR_W], bram_din[DATA_W]  out  SHALL drive the BRAM port.
REQ-013 bram_dout  in  DATA_W  SHALL be the BRAM read data, valid one cycle after a read (en=1, we=0).
REQ-014 busy  out  1  SHALL be high whenever state != IDLE.
REQ-015 sat_flag  out  1  SHALL be a sticky flag raised when any counter saturates.

Function
REQ-016 The FSM SHALL have the states IDLE, INC_RD, INC_WR, CLR, DUMP_RD, DUMP_WAIT, and DUMP_OUT.
REQ-017 IDLE priority SHALL be clr_start > dump_start > evt_valid; starts that arrive outside IDLE are ignored.
REQ-018 evt_ready SHALL equal (state==IDLE && !clr_start && !dump_start).
REQ-019 Event accept in IDLE SHALL register evt_addr and go to INC_RD.
REQ-020 INC_RD SHALL drive bram_en=1, we=0, addr=the registered address, then go to INC_WR.
REQ-021 INC_WR SHALL drive bram_en=1, we=1, din=bram_dout+1, then go to IDLE.
REQ-022 If bram_dout is all-ones in INC_WR, the block SHALL write all-ones and set sat_flag.
REQ-023 Event throughput SHALL be one event per 3 cycles, with evt_ready low during INC_RD and INC_WR.
REQ-024 CLR SHALL write 0 to addresses 0..DEPTH-1, one per cycle (en=1, we=1), then go to IDLE.
REQ-025 CLR SHALL clear sat_flag on entry and SHALL take exactly DEPTH cycles.
REQ-026 Dump SHALL start with an internal index of 0.
REQ-027 DUMP_RD SHALL issue a read of the index; DUMP_WAIT SHALL capture bram_dout into out_data.
REQ-028 DUMP_OUT SHALL assert out_valid, with out_addr=index and out_last=(index==DEPTH-1).
REQ-029 out_data, out_addr, and out_last SHALL stay stable while out_valid && !out_ready.
REQ-030 In DUMP_OUT, on out_valid && out_ready the block SHALL write 0 to the index in the same cycle (read-and-clear).
REQ-031 After that write, the block SHALL go to IDLE if out_last, else increment the index and go to DUMP_RD.
REQ-032 The minimum dump rate SHALL be one word per 3 cycles.
REQ-033 Dump SHALL clear sat_flag when the final word is accepted.
REQ-034 bram_en, bram_we, and bram_din SHALL be 0 in IDLE, DUMP_WAIT, and DUMP_OUT-without-handshake.
REQ-035 The index SHALL not wrap past DEPTH-1; it returns to 0 only on dump or clear start.

Reset
REQ-036 When rst is high, the FSM SHALL go to IDLE on the next edge from any state.
REQ-037 After reset, all of these SHALL be 0: busy, out_valid, out_data, out_addr, out_last, sat_flag, bram_en, bram_we, bram_addr, bram_din, and the index.
REQ-038 Reset SHALL not modify BRAM contents; a counter interrupted between INC_RD and INC_WR is not incremented.
REQ-039 Reset mid-dump SHALL abandon the stream; remaining counters keep their values.
REQ-040 evt_ready SHALL be low while rst is high.

Verification
REQ-041 Bench scenario: clr_start, then events at addr 5 three times and addr 9 once, then dump with out_ready=1 -> 128 words; word 5=3, word 9=1, all others 0; out_last only on addr 127.
REQ-042 Bench scenario: back-to-back evt_valid=1 at addr 2 for 30 cycles -> exactly 10 accepts, counter 2=10, evt_ready high 1 of every 3 cycles.
REQ-043 Bench scenario: preload addr 3=0xFFFFFFFE, then two events at addr 3 -> value 0xFFFFFFFF, sat_flag=1 after the second event; a subsequent clr_start -> sat_flag=0.
REQ-044 Bench scenario: dump with out_ready held low for 5 cycles on word 0 -> out_valid and out_data stable for those 5 cycles, no BRAM write until out_ready=1, then word 0 reads 0 in a second dump.
REQ-045 Bench scenario: clr_start and evt_valid asserted in the same IDLE cycle -> clear wins, evt_ready=0, and the event is held until IDLE resumes after 128 cycles.
REQ-046 Bench scenario: rst asserted during the INC_WR cycle of an event at addr 7 (prior value 4), then during dump word 20 -> addr 7 reads 4 (write suppressed), busy=0, out_valid=0; words 20..127 unchanged in the next dump.

Source files
------------

// File: rtl/bram_count_accumulator.sv
// -----------------------------------------------------------------------------
// bram_count_accumulator
//
// Keeps one counter per measurement outcome in an external single-port BRAM.
// Each accepted event does a read-modify-write (+1, saturating at all-ones) on
// its counter. A clear sweep zeroes every counter. A dump sweep streams every
// counter out over a valid/ready interface and zeroes each one as it is
// accepted (read-and-clear).
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   evt_valid, evt_addr         event request and counter index
//   evt_ready                   event accepted this cycle (combinational)
//   clr_start                   one-cycle pulse: zero all counters
//   dump_start                  one-cycle pulse: stream out and clear all counters
//   out_valid, out_ready        dump stream handshake
//   out_data, out_addr, out_last  dump word, its index, and final-word marker
//   bram_en, bram_we, bram_addr, bram_din  BRAM port drive
//   bram_dout                   BRAM read data, valid one cycle after a read
//   busy                        controller is not idle
//   sat_flag                    sticky: some counter hit all-ones and got another event
// -----------------------------------------------------------------------------
module bram_count_accumulator #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_valid,
  input  logic [ADDR_W-1:0] evt_addr,
  output logic              evt_ready,
  input  logic              clr_start,
  input  logic              dump_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              sat_flag
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INC_RD    = 3'd1,
    INC_WR    = 3'd2,
    CLR       = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_WAIT = 3'd5,
    DUMP_OUT  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  evt_addr_q, evt_addr_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic               out_last_q, out_last_d;
  logic               sat_q, sat_d;

  logic               bram_en_s;
  logic               bram_we_s;
  logic [ADDR_W-1:0]  bram_addr_s;
  logic [DATA_W-1:0]  bram_din_s;

  // Next-state, datapath updates and BRAM port drive for every state.
  always_comb begin
    state_d     = state_q;
    evt_addr_d  = evt_addr_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    bram_en_s   = 1'b0;
    bram_we_s   = 1'b0;
    bram_addr_s = ZERO_A;
    bram_din_s  = ZERO_W;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLR;
          idx_d   = ZERO_A;
          sat_d   = 1'b0;
        end else if (dump_start) begin
          state_d = DUMP_RD;
          idx_d   = ZERO_A;
        end else if (evt_valid) begin
          state_d    = INC_RD;
          evt_addr_d = evt_addr;
        end else begin
          state_d = IDLE;
        end
      end

      INC_RD: begin
        bram_en_s   = 1'b1;
        bram_addr_s = evt_addr_q;
        state_d     = INC_WR;
      end

      INC_WR: begin
        bram_en_s   = 1'b1;
        bram_we_s   = 1'b1;
        bram_addr_s = evt_addr_q;
        // A full counter stays full; the event is recorded only as saturation.
        if (bram_dout == ALL_ONES) begin
          bram_din_s = ALL_ONES;
          sat_d      = 1'b1;
        end else begin
          bram_din_s = bram_dout + DATA_W'(1);
        end
        state_d = IDLE;
      end

      CLR: begin
        bram_en_s   = 1'b1;
        bram_we_s   = 1'b1;
        bram_addr_s = idx_q;
        // Index parks on the last address instead of wrapping.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end

      DUMP_RD: begin
        bram_en_s   = 1'b1;
        bram_addr_s = idx_q;
        state_d     = DUMP_WAIT;
      end

      DUMP_WAIT: begin
        out_data_d = bram_dout;
        out_addr_d = idx_q;
        out_last_d = (idx_q == LAST_IDX);
        state_d    = DUMP_OUT;
      end

      DUMP_OUT: begin
        // The accepted word is cleared in the same cycle as the handshake.
        if (out_ready) begin
          bram_en_s   = 1'b1;
          bram_we_s   = 1'b1;
          bram_addr_s = idx_q;
          if (out_last_q) begin
            state_d = IDLE;
            sat_d   = 1'b0;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = DUMP_RD;
          end
        end else begin
          state_d = DUMP_OUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      evt_addr_q <= ZERO_A;
      idx_q      <= ZERO_A;
      out_data_q <= ZERO_W;
      out_addr_q <= ZERO_A;
      out_last_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      evt_addr_q <= evt_addr_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_last_q <= out_last_d;
      sat_q      <= sat_d;
    end
  end

  // BRAM drive is masked during reset so an interrupted read-modify-write or
  // read-and-clear never reaches memory.
  assign bram_en   = bram_en_s & ~rst;
  assign bram_we   = bram_we_s & ~rst;
  assign bram_addr = rst ? ZERO_A : bram_addr_s;
  assign bram_din  = rst ? ZERO_W : bram_din_s;

  assign evt_ready = (state_q == IDLE) & ~clr_start & ~dump_start & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DUMP_OUT);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule
